hilo_mult_sequencer: RTL and testbench



---
 rtl/hilo_mult_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_hilo_mult_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: multi-cycle HI/LO multiply-accumulate sequencer.
//
// Accepts MULT/MULTU/MADD/MSUB/MTHI/MTLO commands from decode. A radix-2
// shift-add multiply runs on operand magnitudes, and the sign is applied at
// write-back. The block owns the HI/LO registers. While a multiply is in
// flight, it stalls any new HI/LO command or mfhi/mflo read.
//
// Optional build macro:
//   HILO_EARLY_TERM_EN - leave the MUL loop as soon as the remaining
//                        multiplier bits are all zero. Latency becomes
//                        1 + max(1, bitlength(|b|)) instead of WIDTH+1.
//                        HI/LO results are identical in both builds.

module hilo_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    // Command encodings. 11x is a no-op.
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // The iteration counter must be able to hold WIDTH-1.
    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q,  state_d;
    logic [WIDTH-1:0]     hi_q,     hi_d;
    logic [WIDTH-1:0]     lo_q,     lo_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 neg_q,    neg_d;
    logic [2:0]           op_q,     op_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    // ------------------------------------------------------------------
    // Command decode and operand conditioning
    // ------------------------------------------------------------------
    logic                 op_is_mul;
    logic                 op_is_signed;
    logic                 op_is_hilo;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_in;

    // Classify the incoming command and form operand magnitudes for signed ops.
    always_comb begin
        op_is_mul    = (op[2] == 1'b0);
        op_is_signed = op_is_mul && (op != OP_MULTU);
        // A no-op (11x) never touches HI/LO and is never stalled.
        op_is_hilo   = (op[2:1] != 2'b11);
        // Two's-complement negation leaves the most negative value unchanged,
        // which is exactly its magnitude when read as unsigned.
        a_mag        = (op_is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag        = (op_is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_in       = op_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // ------------------------------------------------------------------
    // Write-back arithmetic
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   hilo_cur;
    logic [2*WIDTH-1:0]   hilo_new;

    // Apply the product sign, then combine with HI/LO according to the latched op.
    always_comb begin
        prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
        hilo_cur = {hi_q, lo_q};
        hilo_new = prod;
        case (op_q)
            OP_MADD: hilo_new = hilo_cur + prod;
            OP_MSUB: hilo_new = hilo_cur - prod;
            default: hilo_new = prod;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add step
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   mcand_shifted;

    // Align the multiplicand with the multiplier bit being consumed this edge.
    always_comb begin
        mcand_shifted = {{WIDTH{1'b0}}, mcand_q} << count_q;
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    // Sequence IDLE -> MUL (one multiplier bit per edge) -> WB -> IDLE.
    always_comb begin
        // NOTE: every _d starts from its held value so no branch can leave a
        // signal unassigned and infer a latch.
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            acc_d    = '0;
                            mcand_d  = a_mag;
                            mplier_d = b_mag;
                            neg_d    = neg_in;
                            op_d     = op;
                            count_d  = '0;
                            busy_d   = 1'b1;
                            state_d  = ST_MUL;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_shifted;
                end
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = ST_WB;
                end
`ifdef HILO_EARLY_TERM_EN
                // No set multiplier bits remain, so the accumulator is final.
                if (mplier_d == '0) begin
                    state_d = ST_WB;
                end
`else
`endif
            end

            ST_WB: begin
                {hi_d, lo_d} = hilo_new;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State register with synchronous active-low reset. Any in-flight op is dropped.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge
        // values, independent of statement order.
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            op_q     <= OP_MULT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    // Stall has no register stage, so decode sees it in the same cycle as the request.
    assign stall = busy_q & ((start & op_is_hilo) | rd_req);

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed self-checking bench for hilo_mult_sequencer (WIDTH = 32).
// Expected values are hand-computed constants. Latency expectations follow
// HILO_EARLY_TERM_EN when the bench is built with that macro.

module tb_hilo_mult_sequencer;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b111;

    // Done cycle counted from the accepting edge equals L+1.
    localparam int DONE_FULL = 34;
`ifdef HILO_EARLY_TERM_EN
    localparam int DONE_B0 = 3;
    localparam int DONE_B1 = 3;
    localparam int DONE_B2 = 4;
`else
    localparam int DONE_B0 = 34;
    localparam int DONE_B1 = 34;
    localparam int DONE_B2 = 34;
`endif

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_mult_sequencer #(.WIDTH(32)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_req (rd_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // From the first negedge after the accepting edge (cycle 1), wait for done.
    task automatic wait_done(output int done_cyc, output int busy_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 100 && done_cyc == 0; c++) begin
            if (done) begin
                done_cyc = c;
            end else begin
                if (busy) busy_cnt++;
                @(negedge Clk);
            end
        end
        if (done_cyc == 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    // Issue a multiply and return at the negedge of its done cycle.
    task automatic run_mul(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int done_cyc, output int busy_cnt);
        @(negedge Clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge Clk);
        start = 1'b0; op = OP_NOP;
        wait_done(done_cyc, busy_cnt);
    endtask

    // Issue MTHI/MTLO and return in the following cycle.
    task automatic move_to(input logic [2:0] o, input logic [31:0] x);
        @(negedge Clk);
        start = 1'b1; op = o; a = x;
        @(negedge Clk);
        start = 1'b0; op = OP_NOP;
    endtask

    int dc;
    int bc;
    int pulses;

    initial begin
        Rst_n = 1'b0; start = 1'b0; op = OP_NOP; a = '0; b = '0; rd_req = 1'b0;
        repeat (2) @(negedge Clk);
        rd_req = 1'b1;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        rd_req = 1'b0;
        Rst_n = 1'b1;

        // Full-width unsigned product; fixed latency in both builds.
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
        check("multu_ff_hi", hi, 32'hFFFF_FFFE);
        check("multu_ff_lo", lo, 32'h0000_0001);
        check("multu_ff_busy_cycles", bc, 33);
        check("multu_ff_done_cycle", dc, DONE_FULL);
        check("multu_ff_busy_in_done", busy, 0);
        @(negedge Clk);
        check("done_one_pulse", done, 0);

        // Signed products, including the most negative operand.
        run_mul(OP_MULT, 32'hFFFF_FFFD, 32'd7, dc, bc);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        run_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, dc, bc);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0000_0000);
        check("mult_min_done_cycle", dc, DONE_FULL);

        // Moves, then accumulate and subtract.
        move_to(OP_MTHI, 32'd0);
        check("mthi_hi", hi, 0);
        check("mthi_busy", busy, 0);
        move_to(OP_MTLO, 32'd10);
        check("mtlo_lo", lo, 10);
        check("mtlo_done", done, 0);
        run_mul(OP_MADD, 32'd4, 32'd5, dc, bc);
        check("madd_hi", hi, 0);
        check("madd_lo", lo, 30);
        run_mul(OP_MSUB, 32'hFFFF_FFFE, 32'd3, dc, bc);
        check("msub_neg_hi", hi, 0);
        check("msub_neg_lo", lo, 36);
        move_to(OP_MTLO, 32'd5);
        run_mul(OP_MSUB, 32'd2, 32'd3, dc, bc);
        check("msub_wrap_hi", hi, 32'hFFFF_FFFF);
        check("msub_wrap_lo", lo, 32'hFFFF_FFFF);

        // Stall: rd_req in the first half, a held MTLO in the second half.
        @(negedge Clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
        @(negedge Clk);
        start = 1'b0; op = OP_NOP;
        dc = 0;
        for (int c = 1; c <= 100 && dc == 0; c++) begin
            if (done) begin
                dc = c;
            end else begin
                if (c <= 16) begin
                    rd_req = 1'b1; start = 1'b0; op = OP_NOP;
                end else begin
                    rd_req = 1'b0; start = 1'b1; op = OP_MTLO; a = 32'h0000_1234;
                end
                #1;
                check("stall_busy", stall, 1);
                check("hold_lo_busy", lo, 32'hFFFF_FFFF);
                @(negedge Clk);
            end
        end
        if (dc == 0) check("stall_done_timeout", 64'd0, 64'd1);
        rd_req = 1'b1;
        #1;
        check("stall_done_cycle", dc, DONE_FULL);
        check("stall_in_done", stall, 0);
        check("rd_sees_new_hi", hi, 0);
        check("rd_sees_new_lo", lo, 15);
        @(negedge Clk);
        start = 1'b0; op = OP_NOP; rd_req = 1'b0;
        check("mtlo_after_done_lo", lo, 32'h0000_1234);
        check("mtlo_after_done_hi", hi, 0);
        check("mtlo_after_done_busy", busy, 0);

        // A no-op start is never stalled, even while busy.
        @(negedge Clk);
        start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
        @(negedge Clk);
        op = OP_NOP;
        #1;
        check("nop_busy", busy, 1);
        check("nop_stall", stall, 0);
        start = 1'b0;
        @(negedge Clk);
        wait_done(dc, bc);
        check("nop_mul_lo", lo, 81);

        // Reset during MUL iteration 10 discards the operation.
        @(negedge Clk);
        start = 1'b1; op = OP_MULT; a = 32'h0001_2345; b = 32'h0000_0777;
        @(negedge Clk);
        start = 1'b0; op = OP_NOP;
        repeat (9) @(negedge Clk);
        check("pre_rst_busy", busy, 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1; rd_req = 1'b1;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_stall", stall, 0);
        rd_req = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (done || busy) pulses++;
        end
        check("midrst_no_activity", pulses, 0);
        run_mul(OP_MULTU, 32'd6, 32'd7, dc, bc);
        check("post_rst_hi", hi, 0);
        check("post_rst_lo", lo, 42);

        // Operand-dependent latency (early termination build only).
        run_mul(OP_MULTU, 32'd5, 32'd1, dc, bc);
        check("b1_lo", lo, 5);
        check("b1_done_cycle", dc, DONE_B1);
        run_mul(OP_MULTU, 32'hDEAD_BEEF, 32'd0, dc, bc);
        check("b0_hi", hi, 0);
        check("b0_lo", lo, 0);
        check("b0_done_cycle", dc, DONE_B0);
        run_mul(OP_MULTU, 32'd11, 32'd2, dc, bc);
        check("b2_lo", lo, 22);
        check("b2_done_cycle", dc, DONE_B2);
        run_mul(OP_MULTU, 32'd3, 32'h8000_0000, dc, bc);
        check("bmsb_hi", hi, 1);
        check("bmsb_lo", lo, 32'h8000_0000);
        check("bmsb_done_cycle", dc, DONE_FULL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
